// File: rtl/sw_irq_pkg.sv
// Shared constants for the switch interrupt front end: register map and control states.
package sw_irq_pkg;

    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_PENDING  = 2'd1;
    localparam logic [1:0] REG_MASK     = 2'd2;
    localparam logic [1:0] REG_EDGE_CFG = 2'd3;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a hold-time debounce counter.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic prime,
    input  logic sw_in,
    output logic sync_o,
    output logic stable_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = sw_in;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // While priming, adopt the synchronised level immediately so startup positions are not debounced.
        if (prime) begin
            stable_d = s2_q;
        end else if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync_o   = s2_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/sw_irq_unit.sv
// Switch front end: per-bit debounce, configurable edge capture into W1C pending bits,
// masked interrupt byte and a one-cycle-latency register read/write port.
module sw_irq_unit
    import sw_irq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             reg_we,
    input  logic [1:0]       reg_sel,
    input  logic [WIDTH-1:0] reg_wdata,
    output logic [WIDTH-1:0] reg_rdata,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] irq
);

    state_e           state_q, state_d;
    logic [1:0]       prime_cnt_q, prime_cnt_d;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_cfg_q, edge_cfg_d;
    logic [WIDTH-1:0] irq_q, irq_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] pend_clr;
    logic             prime;

    assign prime = (state_q == PRIME);

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .prime   (prime),
            .sw_in   (sw_in[i]),
            .sync_o  (sync_lvl[i]),
            .stable_o(sw_stable[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        if (state_q == PRIME) begin
            if (prime_cnt_q == 2'd2) begin
                state_d     = RUN;
                prime_cnt_d = 2'd0;
            end else begin
                prime_cnt_d = prime_cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        // Track the level being loaded during priming so the first RUN cycle sees no phantom edge.
        stable_dly_d = prime ? sync_lvl : sw_stable;
        edge_hit     = '0;
        if (!prime) begin
            edge_hit = (sw_stable & ~stable_dly_q & edge_cfg_q)
                     | (~sw_stable & stable_dly_q & ~edge_cfg_q);
        end
        pend_clr   = (reg_we && reg_sel == REG_PENDING) ? reg_wdata : '0;
        pend_d     = (pend_q & ~pend_clr) | edge_hit;
        mask_d     = (reg_we && reg_sel == REG_MASK) ? reg_wdata : mask_q;
        edge_cfg_d = (reg_we && reg_sel == REG_EDGE_CFG) ? reg_wdata : edge_cfg_q;
        irq_d      = pend_q & mask_q;
        case (reg_sel)
            REG_STATUS:  rdata_d = sw_stable;
            REG_PENDING: rdata_d = pend_q;
            REG_MASK:    rdata_d = mask_q;
            default:     rdata_d = edge_cfg_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRIME;
            prime_cnt_q  <= 2'd0;
            stable_dly_q <= '0;
            pend_q       <= '0;
            mask_q       <= '0;
            edge_cfg_q   <= '0;
            irq_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            prime_cnt_q  <= prime_cnt_d;
            stable_dly_q <= stable_dly_d;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            edge_cfg_q   <= edge_cfg_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
        end
    end

    assign irq       = irq_q;
    assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_sw_irq_unit.sv
// Self-checking bench for sw_irq_unit with a short debounce window of 4 cycles.
module tb_sw_irq_unit;
    import sw_irq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_in;
    logic       reg_we;
    logic [1:0] reg_sel;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] sw_stable;
    logic [7:0] irq;

    typedef struct {
        logic       we;
        logic [1:0] sel;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[9];
    int   errors = 0;
    int   checks = 0;

    sw_irq_unit #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_in    (sw_in),
        .reg_we   (reg_we),
        .reg_sel  (reg_sel),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .sw_stable(sw_stable),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        reg_we = 1'b0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.name, reg_rdata, e.exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic access(input logic we, input logic [1:0] sel, input logic [7:0] wdata,
                          input logic [7:0] exp, input string name);
        sb_t e;
        reg_we    = we;
        reg_sel   = sel;
        reg_wdata = wdata;
        e.name    = name;
        e.exp     = exp;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] wdata);
        reg_we    = 1'b1;
        reg_sel   = sel;
        reg_wdata = wdata;
        tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, REG_MASK,     8'h3C, 8'h02};
        tbl[1] = '{1'b0, REG_MASK,     8'h00, 8'h3C};
        tbl[2] = '{1'b1, REG_EDGE_CFG, 8'hA5, 8'h02};
        tbl[3] = '{1'b0, REG_EDGE_CFG, 8'h00, 8'hA5};
        tbl[4] = '{1'b1, REG_STATUS,   8'hFF, 8'h03};
        tbl[5] = '{1'b0, REG_STATUS,   8'h00, 8'h03};
        tbl[6] = '{1'b1, REG_PENDING,  8'h08, 8'h08};
        tbl[7] = '{1'b0, REG_PENDING,  8'h00, 8'h00};
        tbl[8] = '{1'b0, REG_MASK,     8'h00, 8'h3C};

        // Reset with switches set
        reset = 1'b1; sw_in = 8'hA5; reg_we = 1'b0; reg_sel = REG_STATUS; reg_wdata = 8'h00;
        idle(2);
        chk("rst_stable", sw_stable, 8'h00);
        chk("rst_irq", irq, 8'h00);
        chk("rst_rdata", reg_rdata, 8'h00);
        reset = 1'b0;
        wr(REG_MASK, 8'hFF);
        wr(REG_EDGE_CFG, 8'hFF);
        access(1'b0, REG_PENDING, 8'h00, 8'h00, "prime_pend");
        chk("prime_stable", sw_stable, 8'hA5);
        idle(8);
        access(1'b0, REG_PENDING, 8'h00, 8'h00, "after_prime_pend");
        chk("after_prime_irq", irq, 8'h00);
        access(1'b0, REG_STATUS, 8'h00, 8'hA5, "after_prime_status");

        // Glitch rejection and accepted rise on bit 0
        reset = 1'b1; sw_in = 8'h00;
        idle(2);
        reset = 1'b0;
        wr(REG_MASK, 8'h01);
        wr(REG_EDGE_CFG, 8'hFF);
        idle(3);
        sw_in = 8'h01;
        idle(3);
        sw_in = 8'h00;
        idle(10);
        chk("glitch_stable", sw_stable, 8'h00);
        access(1'b0, REG_PENDING, 8'h00, 8'h00, "glitch_pend");
        sw_in = 8'h01;
        idle(5);
        chk("hold_stable_+5", sw_stable, 8'h00);
        idle(1);
        chk("hold_stable_+6", sw_stable, 8'h01);
        chk("hold_irq_+6", irq, 8'h00);
        idle(1);
        chk("hold_pend_+6", reg_rdata, 8'h00);
        chk("hold_irq_+7", irq, 8'h00);
        idle(1);
        chk("hold_pend_+7", reg_rdata, 8'h01);
        chk("hold_irq_+8", irq, 8'h01);

        // Falling edge on bit 3 with masking
        wr(REG_EDGE_CFG, 8'h00);
        wr(REG_MASK, 8'h00);
        wr(REG_PENDING, 8'h01);
        sw_in = 8'h09;
        idle(10);
        access(1'b0, REG_PENDING, 8'h00, 8'h00, "rise_ignored_pend");
        sw_in = 8'h01;
        idle(10);
        access(1'b0, REG_PENDING, 8'h00, 8'h08, "fall_pend");
        chk("fall_masked_irq", irq, 8'h00);
        wr(REG_MASK, 8'h08);
        chk("mask_write_irq", irq, 8'h00);
        idle(1);
        chk("mask_irq", irq, 8'h08);

        // Simultaneous set and W1C clear on bit 1
        wr(REG_EDGE_CFG, 8'h02);
        wr(REG_MASK, 8'h02);
        sw_in = 8'h03;
        idle(6);
        chk("b1_stable", sw_stable, 8'h03);
        access(1'b1, REG_PENDING, 8'h02, 8'h08, "setclr_old_pend");
        access(1'b0, REG_PENDING, 8'h00, 8'h0A, "set_wins_pend");
        chk("set_wins_irq", irq, 8'h02);
        access(1'b1, REG_PENDING, 8'h02, 8'h0A, "clr_write_pend");
        chk("clr_write_irq", irq, 8'h02);
        access(1'b0, REG_PENDING, 8'h00, 8'h08, "clr_done_pend");
        chk("irq_drop", irq, 8'h00);

        // Register port vectors
        for (int i = 0; i < 9; i++) begin
            access(tbl[i].we, tbl[i].sel, tbl[i].wdata, tbl[i].exp, $sformatf("reg_vec%0d", i));
        end
        chk("status_wr_ignored", sw_stable, 8'h03);

        // Reset in the middle of a debounce window
        wr(REG_EDGE_CFG, 8'hFF);
        wr(REG_MASK, 8'hFF);
        access(1'b0, REG_STATUS, 8'h00, 8'h03, "pre_rst_status");
        sw_in = 8'h07;
        idle(4);
        reset = 1'b1;
        idle(1);
        chk("midrst_stable", sw_stable, 8'h00);
        chk("midrst_irq", irq, 8'h00);
        chk("midrst_rdata", reg_rdata, 8'h00);
        reset = 1'b0;
        idle(2);
        chk("reprime_+2", sw_stable, 8'h00);
        idle(1);
        chk("reprime_+3", sw_stable, 8'h07);
        idle(8);
        access(1'b0, REG_PENDING, 8'h00, 8'h00, "midrst_no_pend");
        chk("midrst_final_irq", irq, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_irq_unit.md
# sw_irq_unit

Switch-input front end for the 8-bit core: synchronises and debounces the eight board switches, detects configurable edges, latches them as pending interrupt bits and drives the core's interrupt request byte (nonzero = interrupt). It also exposes the debounced level and its control registers through a one-cycle-latency read/write port, which the top-level memory map decodes (switch read address 998 maps to STATUS).

## Interface
- `WIDTH`, 8: number of switch inputs and interrupt bits.
- `DEBOUNCE_CYCLES`, 65536: consecutive cycles a changed input must hold before it is accepted; minimum 2.
- `clk` in 1: single clock, MAX10_CLK1_50 domain.
- `reset` in 1: synchronous, active-high.
- `sw_in` in WIDTH: raw asynchronous switch levels.
- `reg_we` in 1: write strobe for the register port.
- `reg_sel` in 2: register select (0 STATUS, 1 PENDING, 2 MASK, 3 EDGE_CFG).
- `reg_wdata` in WIDTH: write data.
- `reg_rdata` out WIDTH: registered read data for `reg_sel`.
- `sw_stable` out WIDTH: debounced switch levels.
- `irq` out WIDTH: registered `pending & mask`, connected to the core's interrupt register.

## Operation
- Sync: 2-flop synchroniser per bit (`s1`, `s2`); reset to 0.
- Debounce, per bit: counter of width $clog2(DEBOUNCE_CYCLES). If `s2 == stable`, counter <= 0. Otherwise the counter increments; when it equals DEBOUNCE_CYCLES-1, `stable <= s2` and counter <= 0. A glitch shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
- Control FSM, two states:
  - PRIME, entered on reset: stays 3 cycles via a 2-bit counter. `stable` loads directly from `s2` every cycle. Counters are held at 0 and no edges are reported.
  - RUN, after PRIME: normal debounce. Returns to PRIME only on `reset`.
- Edge detect, RUN only: `stable_q` is `stable` delayed 1 cycle. A bit's edge is a rise if `EDGE_CFG[i]=1` (0->1) and a fall if `EDGE_CFG[i]=0` (1->0).
- Registers:
  - STATUS (RO): `stable`.
  - PENDING (W1C): bit set on edge, independent of MASK.
  - MASK (RW).
  - EDGE_CFG (RW).
  - Writes to STATUS are ignored.
- Same-cycle set and W1C clear on a PENDING bit: set wins, bit stays 1.
- Reset values are all 0: `s1`, `s2`, `stable`, `stable_q`, counters, PENDING, MASK, EDGE_CFG, `reg_rdata`, `irq`.

## Timing
- Raw change to `s2`: 2 cycles.
- `s2` differing to `stable` update: DEBOUNCE_CYCLES cycles, with the change held.
- `stable` change to PENDING bit set: +1 cycle (via `stable_q`).
- PENDING or MASK change to `irq`: +1 cycle.
- Total, raw edge to `irq`: DEBOUNCE_CYCLES + 4 cycles.
- `reg_rdata`: value of the selected register as of the cycle `reg_sel` is presented, valid the next cycle. This matches the RAM read latency.
- A register write takes effect the cycle after `reg_we`. A read of the same register in the write cycle returns the old value.
- `reset` asserted mid-debounce: counters and state are cleared at that edge; no pending edge survives.

## Structure
- Package `sw_irq_pkg`: `reg_sel` constants (REG_STATUS=0, REG_PENDING=1, REG_MASK=2, REG_EDGE_CFG=3) and the FSM enum `{PRIME, RUN}`.
- Sub-module `sw_debounce`: one bit with synchroniser, counter and `stable`, plus a `prime` input. Instantiated WIDTH times via generate.
- Edge detect, registers, FSM and read mux stay in `sw_irq_unit`.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4.)
- **Reset with switches set:** `sw_in=8'hA5` held through reset, MASK=8'hFF, EDGE_CFG=8'hFF → after PRIME `sw_stable=8'hA5`, PENDING stays 8'h00, `irq=8'h00`.
- **Glitch rejection:** `sw_in[0]` pulses high for 3 cycles → `sw_stable` and PENDING unchanged. A 6-cycle hold → `sw_stable[0]=1` exactly 6 cycles after the raw edge, PENDING=8'h01 at +7, `irq=8'h01` at +8 when MASK[0]=1.
- **Falling edge and masking:** EDGE_CFG=8'h00, MASK=8'h00, `sw_in[3]` 1→0 held → PENDING=8'h08 with `irq=8'h00`. Then write MASK=8'h08 → `irq=8'h08` one cycle later.
- **Simultaneous set and clear:** write PENDING=8'h02 in the same cycle bit 1's edge fires → PENDING[1] remains 1. Clearing in a later cycle → 0, and `irq[1]` drops one cycle after.
- **Read port:** write MASK=8'h3C, then read `reg_sel=2` → `reg_rdata=8'h3C` one cycle later. A write to STATUS of 8'hFF leaves the `sw_stable` value unchanged.
- **Mid-debounce reset:** assert `reset` with counter at 2 → all outputs 0 the next cycle, PRIME re-entered, no PENDING set afterwards.
